// File: rtl/elastic_passthrough.sv
// rtl/elastic_passthrough.sv - DEPTH-stage valid/ready register pipeline with flush and occupancy
// Optional XFER_COUNT_EN adds xfer_count, a 16-bit count of output handshakes.
module elastic_passthrough #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] may_load;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_fire;
  logic             out_fire;

  // A stage may load if the output drains or any stage from it to the output is empty;
  // this is the unrolled ready chain, free of combinational self-reference.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      may_load[k] = out_ready;
      for (int j = 0; j < DEPTH; j++) begin
        if (j >= k && !v_q[j]) may_load[k] = 1'b1;
      end
    end
  end

  assign in_ready  = may_load[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = v_q[DEPTH-1] & out_ready & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < DEPTH; k++) d_d[k] = d_q[k];
    if (may_load[0]) begin
      v_d[0] = in_fire;
      d_d[0] = in_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (may_load[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    if (flush) v_d = '0;
  end

  always_comb begin
    occ_d = occ_q;
    case ({in_fire, out_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (flush) occ_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end

`ifdef XFER_COUNT_EN
  logic [15:0] xfer_q, xfer_d;

  always_comb begin
    xfer_d = xfer_q + {15'd0, out_fire};
    if (flush) xfer_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) xfer_q <= '0;
    else      xfer_q <= xfer_d;
  end

  assign xfer_count = xfer_q;
`endif

endmodule

// File: tb/tb_elastic_passthrough.sv
// tb/tb_elastic_passthrough.sv - scoreboard bench for elastic_passthrough (WIDTH=8, DEPTH=4)
module tb_elastic_passthrough;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             CLK;
  logic             RST;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
`ifdef XFER_COUNT_EN
  logic [15:0]      xfer_count;
  logic [15:0]      xfer_model;
`endif

  elastic_passthrough #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } entry_t;

  entry_t           q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;
  bit               exact_lat = 0;
  bit               hold_prev = 0;
  logic [WIDTH-1:0] prev_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: words in flight are the accepted-but-not-delivered queue entries.
  always @(negedge CLK) begin
    entry_t e;
    if (!RST) begin
      q.delete();
      hold_prev = 0;
`ifdef XFER_COUNT_EN
      xfer_model = '0;
`endif
    end else begin
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(!flush && (q.size() < DEPTH || out_ready)));
      if (q.size() == 0) check("out_valid_empty", 64'(out_valid), 64'(0));
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(prev_data));
      end
`ifdef XFER_COUNT_EN
      check("xfer_count", 64'(xfer_count), 64'(xfer_model));
`endif
      if (flush) begin
        q.delete();
        hold_prev = 0;
`ifdef XFER_COUNT_EN
        xfer_model = '0;
`endif
      end else begin
        if (out_valid && out_ready) begin
`ifdef XFER_COUNT_EN
          xfer_model = xfer_model + 16'd1;
`endif
          if (q.size() == 0) begin
            check("unexpected_output", 64'(out_data), 64'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            if (exact_lat) check("latency", 64'(cyc - e.cyc), 64'(DEPTH));
            else           check("latency_min", 64'(cyc - e.cyc >= DEPTH), 64'(1));
          end
        end
        if (in_valid && in_ready) q.push_back('{data: in_data, cyc: cyc});
        hold_prev = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    RST = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    in_valid = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", 64'(out_data), 64'(0));
    @(posedge CLK); #1;
    repeat (DEPTH + 2) tick();

    // Unstalled streaming: exact DEPTH-cycle latency, one word per cycle.
    exact_lat = 1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    drain();
    exact_lat = 0;

    // Backpressure mid-stream.
    fork
      begin
        int idx = 16'h10;
        int guard = 0;
        bit acc;
        while (idx <= 16'h1F && guard < 200) begin
          in_valid = 1'b1;
          in_data  = 8'(idx);
          @(negedge CLK);
          acc = in_valid && in_ready;
          @(posedge CLK); #1;
          if (acc) idx++;
          guard++;
        end
        check("bp_all_sent", 64'(idx), 64'(16'h20));
        in_valid = 1'b0;
      end
      begin
        repeat (6) tick();
        out_ready = 1'b0;
        repeat (6) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Full, then simultaneous in/out.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
    end
    @(negedge CLK);
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    check("full_in_ready", 64'(in_ready), 64'(0));
    @(posedge CLK); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h50 + i);
      @(negedge CLK);
      check("sim_occupancy", 64'(occupancy), 64'(DEPTH));
      check("sim_in_ready", 64'(in_ready), 64'(1));
      @(posedge CLK); #1;
    end
    drain();

    // Flush with three words held and concurrent handshakes offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h60 + i);
      tick();
    end
    in_data = 8'h77; flush = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge CLK); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    check("flush_occupancy", 64'(occupancy), 64'(0));
    check("flush_out_valid", 64'(out_valid), 64'(0));
    @(posedge CLK); #1;
    repeat (8) tick();

    // Random traffic with occasional flush and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      RST       = (i != 200);
      tick();
    end
    flush = 1'b0;
    RST   = 1'b1;
    drain();

`ifdef XFER_COUNT_EN
    RST = 1'b0;
    tick();
    RST = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 8'(i);
      tick();
    end
    drain();
    @(negedge CLK);
    check("xfer_wrap", 64'(xfer_count), 64'(1));
    @(posedge CLK); #1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge CLK);
    check("xfer_flush", 64'(xfer_count), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
